// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the multi-alarm clock core.
// Time is kept as four BCD digits, HH:MM.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_state_t;

  typedef struct packed {
    logic [3:0] hourdec;
    logic [3:0] hourone;
    logic [3:0] mindec;
    logic [3:0] minone;
  } bcd_time_t;

  function automatic logic bcd_valid(input bcd_time_t t);
    logic h_ok;
    h_ok = (t.hourdec < 4'd2 && t.hourone <= 4'd9) ||
           (t.hourdec == 4'd2 && t.hourone <= 4'd3);
    return h_ok && t.mindec <= 4'd5 && t.minone <= 4'd9;
  endfunction

  function automatic bcd_time_t bcd_inc_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.minone != 4'd9) begin
      r.minone = t.minone + 4'd1;
    end else begin
      r.minone = 4'd0;
      if (t.mindec != 4'd5) begin
        r.mindec = t.mindec + 4'd1;
      end else begin
        r.mindec = 4'd0;
        if (t.hourdec == 4'd2 && t.hourone == 4'd3) begin
          r.hourdec = 4'd0;
          r.hourone = 4'd0;
        end else if (t.hourone == 4'd9) begin
          r.hourone = 4'd0;
          r.hourdec = t.hourdec + 4'd1;
        end else begin
          r.hourone = t.hourone + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_multi_core_tone.sv
// Square-wave tone source; counter held at zero while disabled
// so the first edge lands TONE_HALF cycles after enable.
module alarm_tone_gen #(
  parameter int TONE_HALF = 113_636
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic gate,
  output logic aud_pwm
);

  localparam int TW = $clog2(TONE_HALF + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] cnt;
  logic          sq;

  // half-period counter toggling the square wave
  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == T_LAST) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  assign aud_pwm = sq & en & gate;

endmodule

// File: rtl/alarm_multi_core.sv
// BCD time-of-day clock with NUM_ALARMS alarm channels,
// ring/snooze/stop control with timeout, and gated beep tone.
module alarm_multi_core #(
  parameter int SEC_CYCLES     = 100_000_000,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int TONE_HALF      = 113_636
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load_time,
  input  logic [3:0]              hourdec_init,
  input  logic [3:0]              hourone_init,
  input  logic [3:0]              mindec_init,
  input  logic [3:0]              minone_init,
  input  logic [NUM_ALARMS-1:0]   bud_en,
  input  logic [16*NUM_ALARMS-1:0] bud_time,
  input  logic                    snooze,
  input  logic                    stop,
  output logic [3:0]              hourdec_now,
  output logic [3:0]              hourone_now,
  output logic [3:0]              mindec_now,
  output logic [3:0]              minone_now,
  output logic                    clk_sec_o,
  output logic [1:0]              ring_state_o,
  output logic [2:0]              ring_idx_o,
  output logic                    load_err,
  output logic                    aud_pwm
);

  import alarm_pkg::*;

  localparam int DW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SEC_CYCLES - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(SEC_CYCLES / 2);
  localparam logic [11:0]   SNZ_LOAD = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]    RT_LAST  = 8'(RING_TIMEOUT_S - 1);

  logic [DW-1:0] div;
  logic [5:0]    sec;
  bcd_time_t     now, init, nxt;
  ring_state_t   state, state_n;
  logic [2:0]    idx, idx_n, hit_idx;
  logic [7:0]    rcnt, rcnt_n;
  logic [11:0]   scnt, scnt_n;
  logic          tick, load_ok, min_inc, hit;
  logic [7:0]    en_pad;

  assign init    = {hourdec_init, hourone_init,
                    mindec_init, minone_init};
  assign tick    = div == DIV_LAST;
  assign load_ok = load_time && bcd_valid(init);
  assign nxt     = bcd_inc_min(now);
  assign min_inc = tick && sec == 6'd59 && !load_ok;
  assign en_pad  = 8'(bud_en);

  // divider, seconds and BCD time; a valid load overrides the tick
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div       <= '0;
      sec       <= '0;
      now       <= '0;
      clk_sec_o <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      clk_sec_o <= tick;
      load_err  <= load_time && !load_ok;
      if (load_ok) begin
        now <= init;
        sec <= '0;
        div <= '0;
      end else begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) begin
          if (sec == 6'd59) begin
            sec <= '0;
            now <= nxt;
          end else begin
            sec <= sec + 6'd1;
          end
        end
      end
    end
  end

  // lowest enabled alarm equal to the incremented time
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (bud_en[k] && bud_time[16*k +: 16] == nxt) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  // ring state register with owning index and counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      rcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      rcnt  <= rcnt_n;
      scnt  <= scnt_n;
    end
  end

  // ring/snooze/stop next-state; stop beats snooze
  always_comb begin
    state_n = state;
    idx_n   = idx;
    rcnt_n  = rcnt;
    scnt_n  = scnt;
    unique case (state)
      IDLE: begin
        if (min_inc && hit) begin
          state_n = RING;
          idx_n   = hit_idx;
          rcnt_n  = '0;
        end
      end
      RING: begin
        if (!en_pad[idx] || stop) begin
          state_n = IDLE;
        end else if (snooze) begin
          state_n = SNOOZE;
          scnt_n  = SNZ_LOAD;
        end else if (tick) begin
          if (rcnt == RT_LAST) state_n = IDLE;
          else rcnt_n = rcnt + 8'd1;
        end
      end
      SNOOZE: begin
        if (!en_pad[idx] || stop) begin
          state_n = IDLE;
        end else if (min_inc && hit) begin
          state_n = RING;
          idx_n   = hit_idx;
          rcnt_n  = '0;
        end else if (tick) begin
          if (scnt == 12'd1) begin
            state_n = RING;
            rcnt_n  = '0;
          end else begin
            scnt_n = scnt - 12'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign hourdec_now  = now.hourdec;
  assign hourone_now  = now.hourone;
  assign mindec_now   = now.mindec;
  assign minone_now   = now.minone;
  assign ring_state_o = state;
  assign ring_idx_o   = idx;

  alarm_tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk    (clk),
    .rstn   (rstn),
    .en     (state == RING),
    .gate   (div < DIV_HALF),
    .aud_pwm(aud_pwm)
  );

endmodule

// File: tb/tb_alarm_multi_core.sv
// Directed bench for alarm_multi_core: load table plus
// ring, snooze, timeout, enable-drop and reset sequences.
module tb_alarm_multi_core;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_time;
  logic [3:0]  hd_i, ho_i, md_i, mo_i;
  logic [3:0]  bud_en;
  logic [63:0] bud_time;
  logic        snooze, stop;
  logic [3:0]  hd, ho, md, mo;
  logic        clk_sec;
  logic [1:0]  st;
  logic [2:0]  idx;
  logic        lerr;
  logic        aud;
  logic [15:0] now_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign now_w = {hd, ho, md, mo};

  alarm_multi_core #(
    .SEC_CYCLES(10), .NUM_ALARMS(4), .SNOOZE_MIN(1),
    .RING_TIMEOUT_S(5), .TONE_HALF(2)
  ) dut (
    .clk(clk), .rstn(rstn), .load_time(load_time),
    .hourdec_init(hd_i), .hourone_init(ho_i),
    .mindec_init(md_i), .minone_init(mo_i),
    .bud_en(bud_en), .bud_time(bud_time),
    .snooze(snooze), .stop(stop),
    .hourdec_now(hd), .hourone_now(ho),
    .mindec_now(md), .minone_now(mo),
    .clk_sec_o(clk_sec), .ring_state_o(st),
    .ring_idx_o(idx), .load_err(lerr), .aud_pwm(aud)
  );

  typedef struct {
    logic [15:0] ld;
    logic [15:0] exp_now;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] t);
    {hd_i, ho_i, md_i, mo_i} = t;
    load_time = 1'b1;
    @(negedge clk);
    load_time = 1'b0;
  endtask

  task automatic ring_up();
    do_load(16'h0659);
    cyc(600);
  endtask

  initial begin
    int errs;
    logic exp_a;
    tbl[0] = '{16'h1234, 16'h1234, 1'b0};
    tbl[1] = '{16'h2500, 16'h1234, 1'b1};
    tbl[2] = '{16'h1260, 16'h1234, 1'b1};
    tbl[3] = '{16'h2359, 16'h2359, 1'b0};
    tbl[4] = '{16'h2400, 16'h2359, 1'b1};
    tbl[5] = '{16'h1A00, 16'h2359, 1'b1};
    tbl[6] = '{16'h095A, 16'h2359, 1'b1};
    tbl[7] = '{16'h2045, 16'h2045, 1'b0};

    rstn = 1'b0; load_time = 1'b0;
    {hd_i, ho_i, md_i, mo_i} = '0;
    bud_en = '0; bud_time = '0;
    snooze = 1'b0; stop = 1'b0;
    cyc(3);
    chk("rst_now", now_w, 16'h0000);
    chk("rst_state", st, 0);
    chk("rst_idx", idx, 0);
    chk("rst_sec", clk_sec, 0);
    chk("rst_lerr", lerr, 0);
    chk("rst_aud", aud, 0);
    rstn = 1'b1;
    cyc(1);

    // loads must never trigger the alarm matching them
    bud_time = {48'h0, 16'h1234};
    bud_en   = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      {hd_i, ho_i, md_i, mo_i} = tbl[i].ld;
      load_time = 1'b1;
      @(negedge clk);
      load_time = 1'b0;
      chk($sformatf("tbl%0d_err", i), lerr, tbl[i].exp_err);
      chk($sformatf("tbl%0d_now", i), now_w, tbl[i].exp_now);
      chk($sformatf("tbl%0d_st", i), st, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_errlo", i), lerr, 0);
    end
    bud_en = '0;

    // 23:58 -> 23:59 -> 00:00 with 1 Hz pulses
    do_load(16'h2358);
    errs = 0;
    for (int i = 1; i < 600; i++) begin
      @(negedge clk);
      if (clk_sec !== (i % 10 == 0)) errs++;
      if (i == 10) chk("sec_first", clk_sec, 1);
    end
    chk("sec_period", errs, 0);
    chk("t_2358", now_w, 16'h2358);
    cyc(1);
    chk("t_2359", now_w, 16'h2359);
    cyc(600);
    chk("t_0000", now_w, 16'h0000);

    // alarms 0 and 2 at 07:00, alarm 1 same time but disabled
    bud_time = {16'h0000, 16'h0700, 16'h0700, 16'h0700};
    bud_en   = 4'b0101;
    do_load(16'h0659);
    cyc(599);
    chk("pre_ring_st", st, 0);
    chk("pre_ring_now", now_w, 16'h0659);
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("ring_now", now_w, 16'h0700);
        chk("ring_st", st, 1);
        chk("ring_idx", idx, 0);
      end
      exp_a = (((j >> 1) & 1) == 1) && (j % 10 < 5);
      chk($sformatf("aud_j%0d", j), aud, exp_a);
    end
    chk("ring_st49", st, 1);
    cyc(1);
    chk("timeout_st", st, 0);
    chk("timeout_aud", aud, 0);

    // snooze for a full minute, then stop+snooze together
    ring_up();
    chk("r2_st", st, 1);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    chk("snz_st", st, 2);
    chk("snz_aud", aud, 0);
    errs = 0;
    for (int j = 2; j < 600; j++) begin
      @(negedge clk);
      if (st !== 2'd2 || aud !== 1'b0) errs++;
    end
    chk("snz_hold", errs, 0);
    cyc(1);
    chk("snz_back_st", st, 1);
    chk("snz_back_idx", idx, 0);
    chk("snz_back_now", now_w, 16'h0701);
    stop = 1'b1; snooze = 1'b1;
    cyc(1);
    stop = 1'b0; snooze = 1'b0;
    chk("stop_wins", st, 0);

    // dropping the owner's enable while snoozing
    ring_up();
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    cyc(4);
    chk("en_pre", st, 2);
    bud_en = 4'b0100;
    cyc(1);
    chk("en_drop", st, 0);
    bud_en = 4'b0101;

    // reset mid-ring, with a load pulse that must be ignored
    ring_up();
    cyc(3);
    chk("r4_st", st, 1);
    rstn = 1'b0;
    {hd_i, ho_i, md_i, mo_i} = 16'h1234;
    load_time = 1'b1;
    cyc(1);
    chk("mid_rst_now", now_w, 16'h0000);
    chk("mid_rst_st", st, 0);
    chk("mid_rst_aud", aud, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_lerr", lerr, 0);
    rstn = 1'b1;
    load_time = 1'b0;
    cyc(1);
    chk("post_rst_now", now_w, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_multi_core.md
Name: alarm_multi_core

Overview:
- Parametrised successor to the single-alarm clock core.
- Keeps a BCD HH:MM time of day from a 1 Hz tick derived from clk.
- Compares the time against NUM_ALARMS independently enabled alarm times, and runs a ring/snooze/stop state machine with a timeout.
- Drives a gated square-wave tone on aud_pwm.
- Instantiated by the board top; buttons arrive already debounced as single-cycle pulses.

Parameters:
SEC_CYCLES, 100_000_000, clk cycles per second (set small in simulation)
NUM_ALARMS, 4, number of alarm channels (1..8)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_TIMEOUT_S, 60, ring auto-stop in seconds (1..255)
TONE_HALF, 113_636, clk cycles per tone half-period (440 Hz at 100 MHz)

Ports:
clk  in  1  system clock; sole clock
rstn  in  1  reset, synchronous active-low
load_time  in  1  pulse: load init digits as current time
hourdec_init, hourone_init, mindec_init, minone_init  in  4 each  BCD load value
bud_en  in  NUM_ALARMS  per-alarm enable
bud_time  in  16*NUM_ALARMS  alarm k at [16k+15:16k]; digit order {hourdec,hourone,mindec,minone}
snooze  in  1  pulse
stop  in  1  pulse
hourdec_now, hourone_now, mindec_now, minone_now  out  4 each  current BCD time
clk_sec_o  out  1  one-cycle pulse per second
ring_state_o  out  2  FSM state (IDLE=0, RING=1, SNOOZE=2)
ring_idx_o  out  3  index of the owning alarm
load_err  out  1  one-cycle pulse: rejected load
aud_pwm  out  1  tone output

Behaviour:
- Reset (rstn=0 at posedge clk) sets: time 00:00; seconds 0; divider 0; state IDLE; ring_idx_o 0; all pulses 0; aud_pwm 0.
- Divider counts 0..SEC_CYCLES-1. clk_sec_o=1 in the cycle the divider wraps.
- Seconds counter is 6-bit binary, 0..59. On tick with seconds=59: seconds go to 0 and the minute increments in BCD.
- Minute/hour wrap: minone 9->0 carries mindec; mindec 5->0 carries hour; 09->10, 19->20, 23:59->00:00.
- load_time:
  - Valid digits: hour<=23, mindec<=5, minone<=9. A valid load writes the time next cycle and clears seconds and divider.
  - Invalid digits: time unchanged, load_err=1 for one cycle.
  - A load never triggers an alarm. load_time in the same cycle as a tick takes priority over the increment.
- Match:
  - Evaluated only in the cycle the minute increments, on the new time.
  - Alarm k matches if bud_en[k]=1 and bud_time[k] equals the new time.
  - If several match, the lowest index wins.
- FSM:
  - IDLE, on match: RING, ring_idx_o=k, ring-second counter cleared.
  - RING, stop: IDLE.
  - RING, snooze: SNOOZE, with a countdown loaded to SNOOZE_MIN*60 seconds.
  - RING, ring-second counter reaches RING_TIMEOUT_S: IDLE.
  - RING, new match: ignored.
  - SNOOZE, countdown reaches 0 (decrements on ticks): RING, ring counter cleared.
  - SNOOZE, stop: IDLE.
  - SNOOZE, new match from any alarm: RING with the new index.
  - stop and snooze in the same cycle: stop wins.
  - bud_en[ring_idx_o] deasserted in RING or SNOOZE: IDLE next cycle.
  - Valid load_time in RING or SNOOZE: state is kept.
- Tone:
  - Half-period counter toggles a square wave every TONE_HALF cycles.
  - aud_pwm = square AND (state==RING) AND (divider < SEC_CYCLES/2), giving 0.5 s on / 0.5 s off beeps.
  - Outside RING, aud_pwm=0 and the tone counter is held at 0.
  - On entering RING the tone counter restarts from 0, so the first edge comes TONE_HALF cycles later.
- All outputs are registered except aud_pwm, which is an AND of registered terms.

Decomposition:
- Package alarm_pkg holds:
  - enum ring_state_t {IDLE, RING, SNOOZE} (2-bit);
  - packed struct bcd_time_t {hourdec, hourone, mindec, minone};
  - function bcd_valid();
  - function bcd_inc_min().
- One sub-module, alarm_tone_gen (TONE_HALF parameter; inputs en and gate; output aud_pwm), holds the tone counter.

Test Plan:
(SEC_CYCLES=10, TONE_HALF=2, SNOOZE_MIN=1, RING_TIMEOUT_S=5)
1. Reset, then load 23:58 and run 120 s -> time reads 23:59 then 00:00; clk_sec_o pulses every 10 cycles.
2. Load 25:00, then 12:60 -> load_err pulses each time; time stays unchanged.
3. Load 06:59 with alarms 0 and 2 both at 07:00 and enabled -> at the minute increment, ring_state_o=1, ring_idx_o=0; aud_pwm toggles every 2 cycles during the first 5 cycles of each second and is 0 otherwise.
4. Ring, then pulse snooze -> state 2, aud_pwm=0; after 60 ticks state is 1 again; pulse stop and snooze in the same cycle -> state 0.
5. Ring with no input -> returns to state 0 after 5 ticks; clearing bud_en[idx] during SNOOZE -> state 0 next cycle.
6. Assert rstn=0 mid-RING for one cycle -> next cycle: time 00:00, state 0, aud_pwm 0; a pulse on load_time while rstn=0 is ignored.
